// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the programmable display timing block
//
// Purpose: period-state enum used by both axis FSMs, the state successor helper,
//          and the configuration register address map.
// Ports:   none (package).

package display_pkg;

  // Each axis walks these periods in order and wraps back to FRONT.
  typedef enum logic [1:0] {
    FRONT  = 2'd0,
    SYNC   = 2'd1,
    BACK   = 2'd2,
    ACTIVE = 2'd3
  } period_e;

  // Configuration register addresses (shadow/active timing registers).
  localparam logic [2:0] CFG_HFRONT  = 3'd0;
  localparam logic [2:0] CFG_HSYNC   = 3'd1;
  localparam logic [2:0] CFG_HBACK   = 3'd2;
  localparam logic [2:0] CFG_HACTIVE = 3'd3;
  localparam logic [2:0] CFG_VFRONT  = 3'd4;
  localparam logic [2:0] CFG_VSYNC   = 3'd5;
  localparam logic [2:0] CFG_VBACK   = 3'd6;
  localparam logic [2:0] CFG_VACTIVE = 3'd7;

  function automatic period_e next_period(input period_e cur);
    case (cur)
      FRONT:   return SYNC;
      SYNC:    return BACK;
      BACK:    return ACTIVE;
      default: return FRONT;
    endcase
  endfunction

endpackage

// File: rtl/display_axis_fsm.sv
// rtl/display_axis_fsm.sv - one timing axis: period state, countdown and position counter
//
// Purpose: steps FRONT->SYNC->BACK->ACTIVE->FRONT, each period lasting (len+1)
//          enabled clocks; counts the position inside ACTIVE.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   adv                   advance enable (1 = consume one unit of the current period)
//   len_front..len_active period lengths minus one, sampled when a period is loaded
//   sync_nxt, active_nxt  state flags of the value the registers take at the next edge
//   pos_nxt               next position counter (0 outside ACTIVE)
//   at_end                current unit is the last one of ACTIVE

module display_axis_fsm
  import display_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [CW-1:0] len_front,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_back,
  input  logic [CW-1:0] len_active,
  output logic          sync_nxt,
  output logic          active_nxt,
  output logic [CW-1:0] pos_nxt,
  output logic          at_end
);

  period_e       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] pos;

  // cnt holds the units remaining after the current one, so a length value of
  // zero gives a single-unit period and the countdown never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pos_nxt   = pos;
    if (adv) begin
      if (cnt == '0) begin
        state_nxt = next_period(state);
        pos_nxt   = '0;
        case (state_nxt)
          FRONT:   cnt_nxt = len_front;
          SYNC:    cnt_nxt = len_sync;
          BACK:    cnt_nxt = len_back;
          default: cnt_nxt = len_active;
        endcase
      end else begin
        cnt_nxt = cnt - 1'b1;
        if (state == ACTIVE) begin
          pos_nxt = pos + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FRONT;
      cnt   <= len_front;
      pos   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pos   <= pos_nxt;
    end
  end

  assign sync_nxt   = (state_nxt == SYNC);
  assign active_nxt = (state_nxt == ACTIVE);
  assign at_end     = (state == ACTIVE) && (cnt == '0);

endmodule

// File: rtl/display_timing_prog.sv
// rtl/display_timing_prog.sv - programmable display raster timing generator
//
// Purpose: horizontal and vertical timing FSMs producing sync, line/frame
//          strobes and active pixel coordinates. All outputs are registered.
// Optional feature macro: DISPLAY_TIMING_CFG_EN adds shadow timing registers
//          written through cfg_* and committed at the next frame boundary.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   hsync, vsync        sync outputs, polarity set by HS_POL / VS_POL
//   start_line          one-clock pulse on the first clock of each horizontal FRONT
//   start_frame         one-clock pulse with the start_line ending the last active line
//   pxl_accept          high when both axes are ACTIVE
//   pxl_x, pxl_y        active coordinates (0 outside the respective active period)
//   cfg_wr, cfg_addr, cfg_data   shadow register write      (DISPLAY_TIMING_CFG_EN)
//   cfg_commit, cfg_pending      request / pending frame-boundary copy (DISPLAY_TIMING_CFG_EN)

module display_timing_prog
  import display_pkg::*;
#(
  parameter int CW      = 12,
  parameter int HFRONT  = 15,
  parameter int HSYNC   = 95,
  parameter int HBACK   = 47,
  parameter int HACTIVE = 639,
  parameter int VFRONT  = 11,
  parameter int VSYNC   = 1,
  parameter int VBACK   = 29,
  parameter int VACTIVE = 479,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          start_line,
  output logic          start_frame,
  output logic          pxl_accept,
  output logic [CW-1:0] pxl_x,
  output logic [CW-1:0] pxl_y
`ifdef DISPLAY_TIMING_CFG_EN
  ,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_pending
`endif
);

  localparam logic [CW-1:0] PAR [8] = '{
    CW'(HFRONT), CW'(HSYNC), CW'(HBACK), CW'(HACTIVE),
    CW'(VFRONT), CW'(VSYNC), CW'(VBACK), CW'(VACTIVE)
  };

  logic [CW-1:0] len_sel [8];
  logic          h_sync_nxt, h_act_nxt, h_at_end;
  logic          v_sync_nxt, v_act_nxt, v_at_end;
  logic [CW-1:0] h_pos_nxt, v_pos_nxt;
  logic          frame_end;

  assign frame_end = h_at_end & v_at_end;

`ifdef DISPLAY_TIMING_CFG_EN
  logic [CW-1:0] act_q [8];
  logic [CW-1:0] shd_q [8];
  logic          pend_q;
  logic          apply;

  assign apply       = frame_end & pend_q;
  assign cfg_pending = pend_q;

  // On the copy edge the axes load their new FRONT periods straight from the
  // shadows, so the first line of the new frame already uses the new timing.
  // Reset forces parameter values so the reload matches the restored registers.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        len_sel[i] = PAR[i];
      end else if (apply) begin
        len_sel[i] = shd_q[i];
      end else begin
        len_sel[i] = act_q[i];
      end
    end
  end

  // The copy reads the shadows before a same-edge write lands, so a write
  // coincident with the copy only affects the shadow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        act_q[i] <= PAR[i];
        shd_q[i] <= PAR[i];
      end
      pend_q <= 1'b0;
    end else begin
      if (apply) begin
        for (int i = 0; i < 8; i++) begin
          act_q[i] <= shd_q[i];
        end
      end
      if (cfg_wr) begin
        shd_q[cfg_addr] <= cfg_data;
      end
      if (cfg_commit) begin
        pend_q <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end
`else
  assign len_sel = PAR;
`endif

  display_axis_fsm #(.CW(CW)) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (1'b1),
    .len_front  (len_sel[CFG_HFRONT]),
    .len_sync   (len_sel[CFG_HSYNC]),
    .len_back   (len_sel[CFG_HBACK]),
    .len_active (len_sel[CFG_HACTIVE]),
    .sync_nxt   (h_sync_nxt),
    .active_nxt (h_act_nxt),
    .pos_nxt    (h_pos_nxt),
    .at_end     (h_at_end)
  );

  // The vertical axis consumes one line per horizontal ACTIVE end.
  display_axis_fsm #(.CW(CW)) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (h_at_end),
    .len_front  (len_sel[CFG_VFRONT]),
    .len_sync   (len_sel[CFG_VSYNC]),
    .len_back   (len_sel[CFG_VBACK]),
    .len_active (len_sel[CFG_VACTIVE]),
    .sync_nxt   (v_sync_nxt),
    .active_nxt (v_act_nxt),
    .pos_nxt    (v_pos_nxt),
    .at_end     (v_at_end)
  );

  // Outputs are registered from the axes' next-state values so they line up
  // with the state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      start_line  <= 1'b0;
      start_frame <= 1'b0;
      pxl_accept  <= 1'b0;
      pxl_x       <= '0;
      pxl_y       <= '0;
    end else begin
      hsync       <= h_sync_nxt ? HS_POL : ~HS_POL;
      vsync       <= v_sync_nxt ? VS_POL : ~VS_POL;
      start_line  <= h_at_end;
      start_frame <= frame_end;
      pxl_accept  <= h_act_nxt & v_act_nxt;
      pxl_x       <= h_pos_nxt;
      pxl_y       <= v_pos_nxt;
    end
  end

endmodule

// File: tb/tb_display_timing_prog.sv
// tb/tb_display_timing_prog.sv - scoreboard bench for display_timing_prog

module tb_display_timing_prog;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       sl;
    logic       sf;
    logic       acc;
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;

  typedef struct packed {
    int hf; int hs; int hb; int ha;
    int vf; int vs; int vb; int va;
    bit hp; bit vp;
  } tim_t;

  typedef struct packed {
    logic [31:0] n;
    exp_t        ea;
    exp_t        ez;
  } item_t;

  localparam tim_t TA = '{hf:1, hs:1, hb:1, ha:3, vf:0, vs:0, vb:0, va:1, hp:1'b0, vp:1'b0};
  localparam tim_t TZ = '{hf:0, hs:0, hb:0, ha:0, vf:0, vs:0, vb:0, va:0, hp:1'b1, vp:1'b1};

  logic clk;
  logic rst;

  logic       hsync_a, vsync_a, start_line_a, start_frame_a, pxl_accept_a;
  logic [7:0] pxl_x_a, pxl_y_a;
  logic       hsync_z, vsync_z, start_line_z, start_frame_z, pxl_accept_z;
  logic [3:0] pxl_x_z, pxl_y_z;
`ifdef DISPLAY_TIMING_CFG_EN
  logic       cfg_wr, cfg_commit, cfg_pending_a, cfg_pending_z;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       zero1;
  logic [2:0] zero3;
  logic [3:0] zero4;
`endif

  int errors = 0;
  int checks = 0;
  item_t sb_q[$];

  display_timing_prog #(
    .CW(8), .HFRONT(1), .HSYNC(1), .HBACK(1), .HACTIVE(3),
    .VFRONT(0), .VSYNC(0), .VBACK(0), .VACTIVE(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .hsync(hsync_a), .vsync(vsync_a),
    .start_line(start_line_a), .start_frame(start_frame_a),
    .pxl_accept(pxl_accept_a), .pxl_x(pxl_x_a), .pxl_y(pxl_y_a)
`ifdef DISPLAY_TIMING_CFG_EN
    , .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending_a)
`endif
  );

  display_timing_prog #(
    .CW(4), .HFRONT(0), .HSYNC(0), .HBACK(0), .HACTIVE(0),
    .VFRONT(0), .VSYNC(0), .VBACK(0), .VACTIVE(0), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_z (
    .clk(clk), .rst(rst), .hsync(hsync_z), .vsync(vsync_z),
    .start_line(start_line_z), .start_frame(start_frame_z),
    .pxl_accept(pxl_accept_z), .pxl_x(pxl_x_z), .pxl_y(pxl_y_z)
`ifdef DISPLAY_TIMING_CFG_EN
    , .cfg_wr(zero1), .cfg_addr(zero3), .cfg_data(zero4),
    .cfg_commit(zero1), .cfg_pending(cfg_pending_z)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: n clocks after reset, position in line is n mod L, line in frame
  // is (n div L) mod F; each period occupies a fixed range of those positions.
  function automatic exp_t model(input tim_t t, input int n);
    int   len_l, len_f, p, li, hs0, hs1, vs0, vs1, ha0, va0;
    exp_t e;
    len_l = t.hf + t.hs + t.hb + t.ha + 4;
    len_f = t.vf + t.vs + t.vb + t.va + 4;
    p     = n % len_l;
    li    = (n / len_l) % len_f;
    hs0   = t.hf + 1;
    hs1   = t.hf + t.hs + 1;
    ha0   = t.hf + t.hs + t.hb + 3;
    vs0   = t.vf + 1;
    vs1   = t.vf + t.vs + 1;
    va0   = t.vf + t.vs + t.vb + 3;
    e.hs  = (p >= hs0 && p <= hs1) ? t.hp : !t.hp;
    e.vs  = (li >= vs0 && li <= vs1) ? t.vp : !t.vp;
    e.sl  = (n > 0) && (p == 0);
    e.sf  = (n > 0) && (p == 0) && (li == 0);
    e.acc = (p >= ha0) && (li >= va0);
    e.x   = (p >= ha0) ? 8'(p - ha0) : 8'd0;
    e.y   = (li >= va0) ? 8'(li - va0) : 8'd0;
    return e;
  endfunction

  // Monitor: pops one expectation per presented cycle and compares, plus
  // interval measurements between strobes on each instance.
  initial begin : monitor
    item_t it;
    exp_t  obs [2];
    exp_t  ex [2];
    int    sl_prev [2];
    int    sf_prev [2];
    int    acc [2];
    int    llen [2];
    int    flen [2];
    int    apf [2];
    llen = '{10, 4};
    flen = '{50, 16};
    apf  = '{8, 1};
    for (int k = 0; k < 2; k++) begin
      sl_prev[k] = 0; sf_prev[k] = 0; acc[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        obs[0] = {hsync_a, vsync_a, start_line_a, start_frame_a, pxl_accept_a, pxl_x_a, pxl_y_a};
        obs[1] = {hsync_z, vsync_z, start_line_z, start_frame_z, pxl_accept_z,
                  4'b0, pxl_x_z, 4'b0, pxl_y_z};
        ex[0] = it.ea;
        ex[1] = it.ez;
        for (int k = 0; k < 2; k++) begin
          chk(k == 0 ? "a_outputs" : "z_outputs", 32'(obs[k]), 32'(ex[k]));
          if (it.n == 0) begin
            sl_prev[k] = 0; sf_prev[k] = 0; acc[k] = 0;
          end else begin
            if (obs[k].sl) begin
              chk(k == 0 ? "a_line_len" : "z_line_len", it.n - sl_prev[k], llen[k]);
              sl_prev[k] = int'(it.n);
            end
            if (obs[k].sf) begin
              chk(k == 0 ? "a_frame_len" : "z_frame_len", it.n - sf_prev[k], flen[k]);
              chk(k == 0 ? "a_sf_with_sl" : "z_sf_with_sl", 32'(obs[k].sl), 32'd1);
              chk(k == 0 ? "a_acc_per_frame" : "z_acc_per_frame", acc[k], apf[k]);
              sf_prev[k] = int'(it.n);
              acc[k] = 0;
            end
          end
          acc[k] += int'(obs[k].acc);
        end
      end
    end
  end

  initial begin : driver
    int    n_cyc;
    int    rst_pulses;
    exp_t  cur;
    item_t it;
    n_cyc = 0;
    rst_pulses = 0;
    rst = 1'b1;
`ifdef DISPLAY_TIMING_CFG_EN
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
    zero1 = 1'b0; zero3 = 3'd0; zero4 = 4'd0;
`endif
    for (int c = 0; c < 3000; c++) begin
      cur = model(TA, n_cyc);
      if (c < 2) begin
        rst = 1'b1;
      end else if (cur.acc && cur.x == 8'd2 && rst_pulses < 8 && $urandom_range(0, 2) == 0) begin
        rst = 1'b1;
        rst_pulses++;
      end else begin
        rst = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk);
      n_cyc = rst ? 0 : n_cyc + 1;
      it.n  = 32'(n_cyc);
      it.ea = model(TA, n_cyc);
      it.ez = model(TZ, n_cyc);
      sb_q.push_back(it);
      #1;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_active_resets", 32'(rst_pulses > 0), 32'd1);

`ifdef DISPLAY_TIMING_CFG_EN
    begin : cfg_test
      int gap;
      int phase;
      int lines_after;
      bit seen;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("cfg_pending_reset", 32'(cfg_pending_a), 32'd0);
      repeat (23) @(posedge clk);
      #1;
      cfg_addr = 3'd3; cfg_data = 8'd7; cfg_wr = 1'b1;
      @(posedge clk); #1;
      cfg_wr = 1'b0; cfg_commit = 1'b1;
      @(posedge clk); #1;
      cfg_commit = 1'b0;
      chk("cfg_pending_set", 32'(cfg_pending_a), 32'd1);
      gap = 0; phase = 0; lines_after = 0; seen = 1'b0;
      for (int c = 0; c < 400 && lines_after < 2; c++) begin
        @(posedge clk); #1;
        gap++;
        if (start_line_a) begin
          if (phase == 0) begin
            if (seen) chk("cfg_old_line_len", gap, 10);
            if (start_frame_a) begin
              chk("cfg_pending_clear", 32'(cfg_pending_a), 32'd0);
              phase = 1;
            end else begin
              chk("cfg_pending_hold", 32'(cfg_pending_a), 32'd1);
            end
          end else begin
            chk("cfg_new_line_len", gap, 14);
            lines_after++;
          end
          seen = 1'b1;
          gap = 0;
        end
      end
      chk("cfg_new_lines_seen", lines_after, 2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_timing_prog.md
DISPLAY_TIMING_PROG -- requirements
Module: display_timing_prog

Interface
REQ-001 The block SHALL have parameter CW, default 12, giving the counter and coordinate width in bits.
REQ-002 The block SHALL have parameters HFRONT, HSYNC, HBACK, HACTIVE with defaults 15, 95, 47, 639: horizontal period lengths, each stored as length minus one.
REQ-003 The block SHALL have parameters VFRONT, VSYNC, VBACK, VACTIVE with defaults 11, 1, 29, 479: vertical period lengths in lines, each stored as length minus one.
REQ-004 The block SHALL have parameters HS_POL and VS_POL, default 0, giving sync polarity (0 = active-low, 1 = active-high).
REQ-005 The block SHALL have these ports: clk in 1 (sole clock); rst in 1 (reset is synchronous and active-high); hsync out 1; vsync out 1; start_line out 1; start_frame out 1; pxl_accept out 1; pxl_x out CW; pxl_y out CW.
REQ-006 The block SHALL have these ports when DISPLAY_TIMING_CFG_EN is defined: cfg_wr in 1; cfg_addr in 3; cfg_data in CW; cfg_commit in 1; cfg_pending out 1.

Function
REQ-007 Horizontal FSM SHALL cycle FRONT->SYNC->BACK->ACTIVE->FRONT, each period lasting (value+1) clocks; line length = HFRONT+HSYNC+HBACK+HACTIVE+4 clocks.
REQ-008 Vertical FSM SHALL use the same four states and SHALL advance only on the clock where horizontal ACTIVE ends, each period lasting (value+1) lines.
REQ-009 hsync SHALL be asserted (per HS_POL) exactly during horizontal SYNC; vsync SHALL be asserted (per VS_POL) exactly during vertical SYNC lines, changing on line boundaries only.
REQ-010 pxl_accept SHALL be high iff both FSMs are in ACTIVE; pxl_x SHALL be 0..HACTIVE during active, else 0; pxl_y SHALL be 0..VACTIVE during active lines, else 0.
REQ-011 start_line SHALL pulse one clock on the first clock of every horizontal FRONT period.
REQ-012 start_frame SHALL pulse coincident with the start_line that follows the last pixel of line VACTIVE.
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 Countdown arithmetic SHALL use CW bits; a value of 0 SHALL yield a one-clock (or one-line) period, never zero or wrap-around.

Reset
REQ-015 While rst is high at a clock edge, both FSMs SHALL enter FRONT, with countdowns loaded from HFRONT/VFRONT and counters at 0.
REQ-016 During and after reset: hsync and vsync deasserted; start_line, start_frame, pxl_accept at 0; pxl_x and pxl_y at 0; cfg_pending at 0.
REQ-017 Reset mid-line or mid-frame SHALL abort immediately; no start_line or start_frame pulse SHALL result from the abort.
REQ-018 Reset SHALL restore the active and shadow timing registers to parameter values.

Configuration
REQ-019 With DISPLAY_TIMING_CFG_EN defined, the block SHALL write cfg_data to shadow register cfg_addr when cfg_wr is high (0..7 = HFRONT, HSYNC, HBACK, HACTIVE, VFRONT, VSYNC, VBACK, VACTIVE).
REQ-020 With DISPLAY_TIMING_CFG_EN defined, cfg_commit SHALL set cfg_pending; on the next start_frame clock the shadows SHALL copy to active registers and cfg_pending SHALL clear.
REQ-021 With DISPLAY_TIMING_CFG_EN defined, cfg_commit coincident with start_frame SHALL apply at the following frame, and cfg_wr coincident with the copy SHALL land in the shadow register only.
REQ-022 Without DISPLAY_TIMING_CFG_EN, the cfg ports and shadow registers SHALL be absent and timing SHALL be fixed by parameters.

Structure
REQ-023 Package display_pkg SHALL hold the period-state enum (FRONT/SYNC/BACK/ACTIVE) and the cfg register address constants.
REQ-024 A sub-module display_axis_fsm SHALL implement one axis (state, countdown, counter, sync, active, advance-enable input), instantiated twice (horizontal, vertical).

Verification
REQ-025 With CW=8, H=1/1/1/3 and V=0/0/0/1, the bench SHALL confirm: line = 10 clocks; hsync low 2 clocks; pxl_x 0,1,2,3; start_line every 10 clocks.
REQ-026 With the same parameters, the bench SHALL confirm: frame = 5 lines; vsync low 1 line; pxl_accept count 8 per frame; start_frame every 50 clocks, coincident with start_line.
REQ-027 With all timing values 0, the bench SHALL confirm a 4-clock line and a 4-line frame, with no counter wrap.
REQ-028 The bench SHALL assert rst during active pixel pxl_x=2 and confirm next clock all outputs at reset values, with no start_line or start_frame pulse.
REQ-029 With DISPLAY_TIMING_CFG_EN defined, the bench SHALL write HACTIVE=7 then cfg_commit mid-frame, and confirm the current frame keeps the old line length, line length becomes 14 after start_frame, and cfg_pending falls then.
REQ-030 With HS_POL=1 and VS_POL=1, the bench SHALL confirm hsync and vsync are high only during SYNC and low out of reset.
